uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  UART receiver: oversampled 8x, majority-voted, LSB-first 8N1 frames.
//  Each good byte goes into an internal FIFO, which drains over a valid/ready stream.
//  Sits between the board uart_rx pin and the USB CDC IN path (in_data/in_valid/in_ready).
//  The FIFO absorbs USB IN latency, so bytes are not lost while the host is not polling.
// PARAMETERS
//  DATA_WIDTH   8    payload bits per frame
//  FIFO_DEPTH   16   byte entries; power of two, >=2
//  SYNC_STAGES  2    rxd_i synchroniser flops, >=2
// PORTS
//  clk_i             in   1             system clock (48 MHz in the USB designs)
//  rstn_i            in   1             asynchronous, active-low reset
//  rxd_i             in   1             serial line, idle high, asynchronous to clk_i
//  prescale_i        in   16            clk_i cycles per 1/8 bit; 0 is treated as 1
//  m_axis_tdata_o    out  DATA_WIDTH    received byte at FIFO head
//  m_axis_tvalid_o   out  1             FIFO not empty
//  m_axis_tready_i   in   1             consumer accepts head byte
//  busy_o            out  1             frame in progress (state != IDLE)
//  frame_err_o       out  1             1-cycle pulse: stop bit sampled 0
//  overrun_o         out  1             1-cycle pulse: byte dropped, FIFO full
//  parity_err_o      out  1             1-cycle pulse: parity mismatch (0 without macro)
//  fifo_level_o      out  $clog2(D)+1   current FIFO occupancy
// BEHAVIOUR
//  Reset values: tdata 0; tvalid, busy, frame_err, overrun, parity_err 0; level 0.
//    Synchroniser flops reset to 1. State is IDLE.
//  Reset mid-frame: the partial byte is discarded and the FIFO is emptied.
//  Tick: a down-counter reloads with max(prescale_i,1)-1 and pulses at 0.
//    prescale_i is latched on the IDLE->START transition and held for the whole frame.
//  Sub-bit counter: 0..7 per bit, advanced by each tick.
//    Samples are taken at sub-bits 3,4,5; bit value = majority of the three.
//  FSM:
//    IDLE  -> START  on synced rxd==0; tick counter and sub-bit counter cleared.
//    START -> IDLE   if majority==1 (false start, no flag); otherwise -> DATA at sub-bit 7.
//    DATA  8 bits, shifted LSB first; -> PARITY (macro) or STOP after bit 7 sub-bit 7.
//    STOP  decision is made on the sub-bit-5 tick; the FSM does not wait for the bit end.
//      majority==1 -> push the byte, then IDLE.
//      majority==0 -> frame_err pulse, byte dropped, then BREAK.
//    BREAK -> IDLE   on synced rxd==1 (a held-low line yields no bytes).
//  Push: a push is accepted if level<DEPTH or a pop occurs in the same cycle.
//    Otherwise overrun pulses and the byte is dropped; FIFO contents are untouched.
//  Pop: occurs when tvalid && tready.
//    Simultaneous push+pop when full: both take effect and level is unchanged.
//  Latency: byte pushed on the stop-decision cycle; tvalid high on the next cycle if the FIFO was empty.
//  Stream rule: tdata is held stable while tvalid && !tready; tvalid never drops without a pop.
//  Pointers are $clog2(DEPTH) bits and wrap naturally.
//  Level is $clog2(DEPTH)+1 bits: +1 on push only, -1 on pop only.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//    PARITY state after DATA, one bit, even parity over data+parity bit.
//    Mismatch -> parity_err pulse at the parity sample; byte dropped; the STOP check still runs.
//    If the stop bit is also bad, both flags pulse, each in its own cycle.
//  UART_RX_PARITY_EN undefined: no PARITY state, 8N1 only; parity_err_o tied 0.
// STRUCTURE
//  Package uart_rx_pkg: FSM state enum (IDLE, START, DATA, PARITY, STOP, BREAK),
//    SUBBITS=8, SAMPLE_LO=3, SAMPLE_MID=4, SAMPLE_HI=5.
//  Sub-module sync_fifo (DATA_WIDTH, DEPTH): push/pop/full/empty/level, registered read head.
//    The receiver FSM, tick counter and synchroniser live in uart_rx_fifo.
// TESTING  (prescale_i=4, i.e. 32 clk per bit; FIFO_DEPTH=4 unless noted)
//  1. 8N1 byte 0xA5, tready=1 -> exactly one beat, tdata=0xA5.
//     tvalid rises 1 cycle after the stop sample; no error pulses.
//  2. rxd low for 8 clk, then high -> no beat, no flags; busy returns to 0.
//  3. 0x3C with stop bit=0 -> frame_err 1 cycle, level stays 0.
//     Line held low 200 clk gives no bytes; then high, then 0x55 -> one beat 0x55.
//  4. tready=0; send 0x01..0x05 -> level=4, overrun pulses on the 5th byte.
//     Then tready=1 -> beats 01,02,03,04 in order.
//  5. rstn_i low during DATA bit 3 -> outputs at reset values.
//     After release, next frame 0xC3 is received correctly.
//  6. With UART_RX_PARITY_EN: 0x81 with parity bit=1 -> parity_err pulse, no beat.
//     0x81 with parity bit=0 -> beat 0x81.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

    localparam int SUBBITS = 8;
    localparam int SUB_W   = $clog2(SUBBITS);

    localparam logic [SUB_W-1:0] SAMPLE_LO  = SUB_W'(3);
    localparam logic [SUB_W-1:0] SAMPLE_MID = SUB_W'(4);
    localparam logic [SUB_W-1:0] SAMPLE_HI  = SUB_W'(5);
    localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(SUBBITS - 1);

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO with a registered head word; a push is taken
// when not full or when a pop happens in the same cycle.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    push_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    input  logic                    pop_i,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  level_o
);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]           level_q, level_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic                  push_ok, pop_ok;

    assign full_o  = (level_q == (PW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign data_o  = head_q;
    assign level_o = level_q;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push_ok && !pop_ok)
            level_d = level_q + (PW+1)'(1);
        else if (!push_ok && pop_ok)
            level_d = level_q - (PW+1)'(1);
        // The incoming word becomes the head directly when nothing older survives this cycle.
        head_d = head_q;
        if (push_ok && (level_q == {{PW{1'b0}}, pop_ok}))
            head_d = data_i;
        else if (level_d != '0)
            head_d = mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk_i) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8x-oversampled, majority-voted UART receiver feeding a stream FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        rxd_i,
    input  logic [15:0]                 prescale_i,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata_o,
    output logic                        m_axis_tvalid_o,
    input  logic                        m_axis_tready_i,
    output logic                        busy_o,
    output logic                        frame_err_o,
    output logic                        overrun_o,
    output logic                        parity_err_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);
    localparam int BW = $clog2(DATA_WIDTH);

    rx_state_e             state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                  rxd_s;
    logic [15:0]           reload_q, reload_d, tick_cnt_q, tick_cnt_d;
    logic [SUB_W-1:0]      sub_q, sub_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic                  s_lo_q, s_lo_d, s_mid_q, s_mid_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic                  tick, at_hi, at_end, maj, keep, push_req, pop;
    logic                  fifo_full, fifo_empty;

`ifdef UART_RX_PARITY_EN
    logic par_err_q, par_err_d, drop_q, drop_d;
    assign keep         = !drop_q;
    assign parity_err_o = par_err_q;
`else
    assign keep         = 1'b1;
    assign parity_err_o = 1'b0;
`endif

    assign rxd_s  = sync_q[SYNC_STAGES-1];
    assign tick   = (state_q != IDLE) && (tick_cnt_q == '0);
    assign at_hi  = tick && (sub_q == SAMPLE_HI);
    assign at_end = tick && (sub_q == SUB_LAST);
    assign maj    = maj3(s_lo_q, s_mid_q, rxd_s);
    assign pop    = m_axis_tvalid_o && m_axis_tready_i;

    always_comb begin
        state_d     = state_q;
        reload_d    = reload_q;
        sub_d       = sub_q;
        bit_d       = bit_q;
        s_lo_d      = s_lo_q;
        s_mid_d     = s_mid_q;
        shreg_d     = shreg_q;
        push_req    = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d   = 1'b0;
        drop_d      = drop_q;
`endif
        tick_cnt_d  = tick_cnt_q - 16'd1;
        if (tick) begin
            tick_cnt_d = reload_q;
            sub_d      = sub_q + SUB_W'(1);
            if (sub_q == SAMPLE_LO)  s_lo_d  = rxd_s;
            if (sub_q == SAMPLE_MID) s_mid_d = rxd_s;
        end

        unique case (state_q)
            IDLE: begin
                tick_cnt_d = '0;
                sub_d      = '0;
                bit_d      = '0;
`ifdef UART_RX_PARITY_EN
                drop_d     = 1'b0;
`endif
                if (!rxd_s) begin
                    state_d  = START;
                    reload_d = (prescale_i == 16'd0) ? 16'd0 : prescale_i - 16'd1;
                end
            end
            START: begin
                if (at_hi && maj)
                    state_d = IDLE;
                else if (at_end)
                    state_d = DATA;
            end
            DATA: begin
                if (at_hi)
                    shreg_d = {maj, shreg_q[DATA_WIDTH-1:1]};
                if (at_end) begin
                    if (bit_q == BW'(DATA_WIDTH - 1))
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    else
                        bit_d = bit_q + BW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (at_hi && ((^shreg_q) ^ maj)) begin
                    par_err_d = 1'b1;
                    drop_d    = 1'b1;
                end
                if (at_end)
                    state_d = STOP;
            end
`endif
            STOP: begin
                // Decide mid-stop-bit so back-to-back frames are not clipped.
                if (at_hi) begin
                    if (maj) begin
                        push_req = keep;
                        state_d  = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rxd_s)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign overrun_d = push_req && fifo_full && !pop;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            sync_q      <= '1;
            reload_q    <= '0;
            tick_cnt_q  <= '0;
            sub_q       <= '0;
            bit_q       <= '0;
            s_lo_q      <= 1'b1;
            s_mid_q     <= 1'b1;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= 1'b0;
            drop_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[SYNC_STAGES-2:0], rxd_i};
            reload_q    <= reload_d;
            tick_cnt_q  <= tick_cnt_d;
            sub_q       <= sub_d;
            bit_q       <= bit_d;
            s_lo_q      <= s_lo_d;
            s_mid_q     <= s_mid_d;
            shreg_q     <= shreg_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= par_err_d;
            drop_q      <= drop_d;
`endif
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (push_req),
        .data_i  (shreg_q),
        .pop_i   (pop),
        .data_o  (m_axis_tdata_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level_o)
    );

    assign m_axis_tvalid_o = !fifo_empty;

endmodule
